eth_crc_stream: RTL
===================

# eth_crc_stream

Parametrised CRC-32 stream engine for the Ethernet MAC datapath. It processes a framed data stream of DATA_W bits per beat and runs in one of two modes, latched per frame:
- **TX:** appends the 32-bit FCS after the last data beat.
- **RX:** passes data through and flags a CRC mismatch at frame end.

It sits between the MAC framing logic and the MII/GMII adapters and generalises the fixed nibble-wide CRC register to 1/2/4/8-bit beats, adding frame sequencing and FCS insertion.

## Interface
- DATA_W, 8, beat width; legal values 1, 2, 4, 8. Derived constant FCS_BEATS = 32/DATA_W.
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- TxMode  in  1  sampled on the accepted Start beat; 1 = generate/append, 0 = check
- Abort  in  1  synchronous; drops the current frame
- InValid  in  1  input beat valid
- InReady  out  1  block accepts a beat (combinational from state)
- InData  in  DATA_W  data; bit 0 is first on the wire
- InStart  in  1  first beat of frame
- InEnd  in  1  last beat of frame
- OutValid  out  1  output beat valid
- OutData  out  DATA_W  output beat
- OutFcs  out  1  output beat is FCS
- OutEnd  out  1  last output beat of frame
- Done  out  1  one-cycle frame-complete pulse
- CrcError  out  1  RX result, valid while Done=1; 0 in TX
- Crc  out  32  CRC register

## Operation
**CRC arithmetic**
- Polynomial 0x04C11DB7, initial value 0xFFFFFFFF, non-reflected register.
- Per beat, bits are processed InData[0] first, one at a time: fb = bit ^ Crc[31]; Crc = {Crc[30:0],0} ^ (fb ? 0x04C11DB7 : 0). One full beat is applied per clock.
- FCS beat k (k = 0..FCS_BEATS-1): OutData[j] = ~Crc[31 - k*DATA_W - j].
- RX check: after the received FCS is absorbed, the frame is good iff Crc == 0xC704DD7B.

**States**
- IDLE
  - InReady=1.
  - Beat accepted (InValid&InReady) with InStart: CRC = update(0xFFFFFFFF, InData); TxMode latched; go to DATA.
  - Beats without InStart are discarded and produce no output.
- DATA
  - InReady=1. Each accepted beat updates Crc and is forwarded.
  - Accepted beat with InEnd:
    - TX: go to FCS.
    - RX: CrcError = (updated Crc != 0xC704DD7B), Done=1, go to IDLE.
  - Start&End on the same beat is a single-beat frame: IDLE handles End directly.
- FCS (TX only)
  - InReady=0.
  - Beat counter 0..FCS_BEATS-1 emits FCS beats with OutFcs=1; the last beat has OutEnd=1 and Done=1.
  - Crc is not modified in this state; it holds the final frame CRC.
  - Then go to IDLE.

**Boundary conditions**
- InStart accepted in DATA: the current frame is dropped with no Done and no OutEnd; the beat restarts CRC as a new frame with TxMode re-sampled.
- Abort:
  - Highest priority; takes effect at the next edge.
  - Goes to IDLE, Crc=0xFFFFFFFF, no Done.
  - Any beat accepted in the same cycle is discarded.
  - An FCS sequence in progress is truncated; the beat already registered remains visible for one cycle.
- InValid=0 in DATA: hold Crc and state; OutValid=0 next cycle.
- Crc holds its value in IDLE until the next accepted Start or Abort.
- Reset mid-frame: immediate return to IDLE with reset values; no Done.

**Reset values**
- State IDLE, so InReady=1.
- Crc=0xFFFFFFFF.
- OutValid, OutData, OutFcs, OutEnd, Done, CrcError all 0.
- FCS counter 0; latched mode 0.

## Timing
- Data path: each beat accepted at edge T appears on OutData/OutValid in cycle T+1, with OutEnd for the RX last beat. Crc reflects that beat in cycle T+1.
- RX: Done and CrcError are asserted in the same cycle as the OutEnd data beat (T+1).
- TX, End accepted at edge T:
  - Last data beat at T+1.
  - FCS beats at T+2 .. T+1+FCS_BEATS, gap-free after the data.
  - InReady=0 in cycles T+1 .. T+FCS_BEATS; InReady=1 again in cycle T+1+FCS_BEATS, when OutEnd and Done are asserted.
- A new Start accepted in cycle T+1+FCS_BEATS is legal, giving back-to-back frames.
- Done is exactly one cycle wide. All outputs except InReady are registered.

## Test plan
- **TX, DATA_W=8:** ASCII "123456789" (0x31..0x39), Start on first beat, End on last → OutData 0x31..0x39, then OutFcs beats 0x26, 0x39, 0xF4, 0xCB. OutEnd and Done are on 0xCB; InReady is low for exactly 4 cycles.
- **RX, DATA_W=8:** "123456789" followed by 0x26, 0x39, 0xF4, 0xCB → Done with CrcError=0 and Crc=0xC704DD7B. Flip bit 0 of the last byte → CrcError=1.
- **DATA_W=4:** the same frame as nibbles, low nibble first. TX yields 8 FCS nibbles 6, 2, 9, 3, 4, F, B, C; an RX loopback of the TX output gives CrcError=0.
- **Back-to-back and stalls:** two TX frames with the second Start in the cycle InReady returns high; random InValid gaps in DATA → no output gaps in FCS, correct FCS for both frames, exactly 2 Done pulses.
- **Protocol errors:**
  - InStart mid-frame → first frame produces no Done; second frame's FCS is correct.
  - Abort during FCS beat 1 → at most one further FCS beat, no Done, Crc=0xFFFFFFFF.
  - Beat without Start in IDLE → no output.
- **Reset:** assert Reset asynchronously mid-DATA → outputs 0, Crc=0xFFFFFFFF and InReady=1 immediately. After release a full frame is processed correctly.

Source files
------------

// File: rtl/eth_crc_stream.sv
// CRC-32 stream engine: TX appends the FCS after the last data beat, RX passes data
// through and flags a residue mismatch at frame end. DATA_W in {1,2,4,8}.
module eth_crc_stream #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_mode_i,
  input  logic              abort_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_start_i,
  input  logic              in_end_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_fcs_o,
  output logic              out_end_o,
  output logic              done_o,
  output logic              crc_error_o,
  output logic [31:0]       crc_o
);

  localparam int          FCS_BEATS = 32 / DATA_W;
  localparam int          CNT_W     = $clog2(FCS_BEATS);
  localparam logic [31:0] POLY      = 32'h04C11DB7;
  localparam logic [31:0] INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE   = 32'hC704DD7B;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FCS_BEATS - 1);

  typedef enum logic [1:0] {IDLE, DATA, FCS} state_e;

  state_e            state_q, state_d;
  logic [31:0]       crc_q, crc_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ov_q, ov_d, ofcs_q, ofcs_d, oend_q, oend_d;
  logic              done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic [DATA_W-1:0] fcs_beat;
  logic [31:0]       fcs_sh;
  logic              tx_sel;

  // Bit-serial update, in_data[0] first, unrolled across the beat.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < DATA_W; i++)
      r = {r[30:0], 1'b0} ^ ((d[i] ^ r[31]) ? POLY : 32'h0);
    return r;
  endfunction

  assign in_ready_o = (state_q != FCS);

  always_comb begin
    fcs_sh   = crc_q << (int'(cnt_q) * DATA_W);
    fcs_beat = '0;
    for (int j = 0; j < DATA_W; j++) fcs_beat[j] = ~fcs_sh[31-j];
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    od_d    = '0;
    ofcs_d  = 1'b0;
    oend_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tx_sel  = mode_q;
    if (abort_i) begin
      state_d = IDLE;
      crc_d   = INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DATA: begin
          // A Start seen in DATA silently drops the open frame and restarts.
          if (in_valid_i && (in_start_i || state_q == DATA)) begin
            tx_sel  = in_start_i ? tx_mode_i : mode_q;
            crc_d   = crc_step(in_start_i ? INIT : crc_q, in_data_i);
            mode_d  = tx_sel;
            ov_d    = 1'b1;
            od_d    = in_data_i;
            cnt_d   = '0;
            state_d = DATA;
            if (in_end_i) begin
              if (tx_sel) begin
                state_d = FCS;
              end else begin
                oend_d  = 1'b1;
                done_d  = 1'b1;
                err_d   = (crc_d != RESIDUE);
                state_d = IDLE;
              end
            end
          end
        end
        FCS: begin
          ov_d   = 1'b1;
          ofcs_d = 1'b1;
          od_d   = fcs_beat;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            oend_d  = 1'b1;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ofcs_q  <= 1'b0;
      oend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ofcs_q  <= ofcs_d;
      oend_q  <= oend_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_fcs_o   = ofcs_q;
  assign out_end_o   = oend_q;
  assign done_o      = done_q;
  assign crc_error_o = err_q;
  assign crc_o       = crc_q;

endmodule
